// File: rtl/hir_memref_responder.sv
// Responder end of the HIR memref read/write port: zeroes its storage after reset,
// then serves one read and one write per cycle with a fixed-latency read pipeline.
module hir_memref_responder #(
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              access_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              fsm_state
);

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              rd_acc;
    logic              wr_acc;

    // Read pipeline; data in a stage only moves when a valid word moves, so the
    // last stage holds the most recent response between responses.
    logic              pv [RD_LATENCY];
    logic [WIDTH-1:0]  pd [RD_LATENCY];

    assign rd_acc    = (state == SERVE) && rd_en;
    assign wr_acc    = (state == SERVE) && wr_en;
    assign fsm_state = state;
    assign rd_valid  = pv[RD_LATENCY-1];
    assign rd_data   = pd[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            busy       <= 1'b1;
            access_err <= 1'b0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (rd_en || wr_en)
                        access_err <= 1'b1;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= SERVE;
                        busy  <= 1'b0;
                    end
                end
                SERVE: begin
                    if (rd_acc && rd_count != 16'hFFFF)
                        rd_count <= rd_count + 16'd1;
                    if (wr_acc && wr_count != 16'hFFFF)
                        wr_count <= wr_count + 16'd1;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset of its own; CLEAR is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (wr_acc)
                mem[wr_addr] <= wr_data;
        end
    end

    // Reading mem here sees the pre-edge word, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc)
                pd[0] <= mem[rd_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1])
                    pd[i] <= pd[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hir_memref_responder.sv
// Directed bench for hir_memref_responder: one latency-1 and one latency-3 instance
// share the same stimulus; each step compares against hand-computed values.
module tb_hir_memref_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rd_addr;
    logic        rd_en;
    logic [5:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;

    logic [31:0] rd_data_1, rd_data_3;
    logic        rd_valid_1, rd_valid_3;
    logic        busy_1, busy_3;
    logic        access_err_1, access_err_3;
    logic [15:0] rd_count_1, rd_count_3;
    logic [15:0] wr_count_1, wr_count_3;
    logic        fsm_state_1, fsm_state_3;

    int passed = 0;
    int total  = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    always #5 clk = ~clk;

    hir_memref_responder #(.DEPTH(64), .ADDR_W(6), .WIDTH(32), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_1), .rd_valid(rd_valid_1), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy_1), .access_err(access_err_1),
        .rd_count(rd_count_1), .wr_count(wr_count_1), .fsm_state(fsm_state_1)
    );

    hir_memref_responder #(.DEPTH(64), .ADDR_W(6), .WIDTH(32), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_3), .rd_valid(rd_valid_3), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy_3), .access_err(access_err_3),
        .rd_count(rd_count_3), .wr_count(wr_count_3), .fsm_state(fsm_state_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts cycles until busy drops (bounded) and notes any response seen meanwhile.
    task automatic wait_clear(output int n, output logic seen);
        n = 0;
        seen = 1'b0;
        while (busy_1 === 1'b1 && n < 200) begin
            tick();
            n++;
            if (rd_valid_1 !== 1'b0 || rd_valid_3 !== 1'b0)
                seen = 1'b1;
        end
    endtask

    task automatic write_word(input logic [5:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        exp_wr++;
    endtask

    task automatic read_check(input logic [5:0] addr, input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en   = 1'b0;
        exp_rd++;
        chk({tag, "_valid"}, 32'(rd_valid_1), 32'd1);
        chk({tag, "_data"}, rd_data_1, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen;

        rst_n   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = 6'd0;
        wr_addr = 6'd0;
        wr_data = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(busy_1), 32'd1);
        chk("rst_valid", 32'(rd_valid_1), 32'd0);
        chk("rst_data", rd_data_1, 32'd0);
        chk("rst_rd_count", 32'(rd_count_1), 32'd0);
        chk("rst_wr_count", 32'(wr_count_1), 32'd0);
        chk("rst_err", 32'(access_err_1), 32'd0);
        chk("rst_state", 32'(fsm_state_1), 32'd0);
        chk("rst_data3", rd_data_3, 32'd0);

        // Clear sequence lasts exactly 64 cycles
        rst_n = 1'b1;
        wait_clear(n, seen);
        chk("clear_len", 32'(n), 32'd64);
        chk("clear_no_valid", 32'(seen), 32'd0);
        chk("clear_busy3", 32'(busy_3), 32'd0);
        chk("serve_state", 32'(fsm_state_1), 32'd1);

        read_check(6'd0, 32'd0, "rd0");
        read_check(6'd31, 32'd0, "rd31");
        read_check(6'd63, 32'd0, "rd63");
        tick();
        chk("idle_valid", 32'(rd_valid_1), 32'd0);

        // Write then read back
        write_word(6'd5, 32'hDEADBEEF);
        read_check(6'd5, 32'hDEADBEEF, "rd5");
        chk("wr_count_1", 32'(wr_count_1), 32'd1);
        chk("rd_count_4", 32'(rd_count_1), 32'd4);

        // Same-edge read/write returns the old word
        write_word(6'd9, 32'h7);
        rd_en = 1'b1; rd_addr = 6'd9;
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h1;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        exp_rd++; exp_wr++;
        chk("rf_valid", 32'(rd_valid_1), 32'd1);
        chk("rf_old", rd_data_1, 32'h7);
        read_check(6'd9, 32'h1, "rf_new");

        // Read and write different addresses together
        rd_en = 1'b1; rd_addr = 6'd5;
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'hA5A50001;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        exp_rd++; exp_wr++;
        chk("dual_rd", rd_data_1, 32'hDEADBEEF);
        read_check(6'd10, 32'hA5A50001, "dual_wr");
        tick();
        chk("hold_valid", 32'(rd_valid_1), 32'd0);
        chk("hold_data", rd_data_1, 32'hA5A50001);
        chk("rd_count_model", 32'(rd_count_1), 32'(exp_rd));
        chk("wr_count_model", 32'(wr_count_1), 32'(exp_wr));

        // Latency-3 pipeline, back-to-back reads
        write_word(6'd1, 32'h11111111);
        write_word(6'd2, 32'h22222222);
        write_word(6'd3, 32'h33333333);
        tick(); tick(); tick();
        rd_en = 1'b1; rd_addr = 6'd1;
        tick();
        chk("l1_a", rd_data_1, 32'h11111111);
        chk("l3_none_a", 32'(rd_valid_3), 32'd0);
        rd_addr = 6'd2;
        tick();
        chk("l1_b", rd_data_1, 32'h22222222);
        chk("l3_none_b", 32'(rd_valid_3), 32'd0);
        rd_addr = 6'd3;
        tick();
        rd_en = 1'b0;
        exp_rd += 3;
        chk("l1_c", rd_data_1, 32'h33333333);
        chk("l3_v1", 32'(rd_valid_3), 32'd1);
        chk("l3_d1", rd_data_3, 32'h11111111);
        tick();
        chk("l3_v2", 32'(rd_valid_3), 32'd1);
        chk("l3_d2", rd_data_3, 32'h22222222);
        tick();
        chk("l3_v3", 32'(rd_valid_3), 32'd1);
        chk("l3_d3", rd_data_3, 32'h33333333);
        tick();
        chk("l3_end", 32'(rd_valid_3), 32'd0);
        chk("l3_hold", rd_data_3, 32'h33333333);
        chk("rd_count3", 32'(rd_count_3), 32'(exp_rd));

        // Access during CLEAR is ignored and flagged
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rd = 0; exp_wr = 0;
        chk("rst2_busy", 32'(busy_1), 32'd1);
        chk("rst2_err", 32'(access_err_1), 32'd0);
        repeat (9) tick();
        rd_en = 1'b1; rd_addr = 6'd0;
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'hFFFFFFFF;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (rd_valid_1 !== 1'b0 || rd_valid_3 !== 1'b0) seen = 1'b1;
        end
        chk("busy_no_valid", 32'(seen), 32'd0);
        chk("busy_err", 32'(access_err_1), 32'd1);
        chk("busy_rd_count", 32'(rd_count_1), 32'd0);
        chk("busy_wr_count", 32'(wr_count_1), 32'd0);
        wait_clear(n, seen);
        chk("clear2_rest", 32'(n), 32'd50);
        chk("err_sticky", 32'(access_err_1), 32'd1);
        read_check(6'd0, 32'd0, "busy_wr_ignored");

        // Reset one cycle after a read drops the in-flight response
        write_word(6'd12, 32'h12121212);
        rd_en = 1'b1; rd_addr = 6'd12;
        tick();
        rd_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rd = 0; exp_wr = 0;
        chk("flush_valid3", 32'(rd_valid_3), 32'd0);
        chk("flush_data3", rd_data_3, 32'd0);
        chk("flush_valid1", 32'(rd_valid_1), 32'd0);
        chk("flush_busy", 32'(busy_1), 32'd1);
        wait_clear(n, seen);
        chk("clear3_len", 32'(n), 32'd64);
        chk("clear3_no_valid", 32'(seen), 32'd0);
        read_check(6'd12, 32'd0, "rd12_zero");
        read_check(6'd5, 32'd0, "rd5_zero");
        chk("final_rd_count", 32'(rd_count_1), 32'(exp_rd));
        chk("final_wr_count", 32'(wr_count_1), 32'(exp_wr));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hir_memref_responder.md
HIR_MEMREF_RESPONDER -- requirements
Module: hir_memref_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of storage words.
REQ-002 Parameter ADDR_W, default 6: address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter WIDTH, default 32: data word width.
REQ-004 Parameter RD_LATENCY, default 1, legal range 1..4: cycles from rd_en sample to rd_data valid.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 rd_addr  input  ADDR_W  read-port address from the initiator.
REQ-008 rd_en  input  1  read request, one word per asserted cycle.
REQ-009 rd_data  output  WIDTH  read response word.
REQ-010 rd_valid  output  1  high in the cycle rd_data carries a response.
REQ-011 wr_addr  input  ADDR_W  write-port address.
REQ-012 wr_en  input  1  write request, one word per asserted cycle.
REQ-013 wr_data  input  WIDTH  write data.
REQ-014 busy  output  1  high while the post-reset clear sequence runs.
REQ-015 access_err  output  1  sticky; set when rd_en or wr_en is seen while busy.
REQ-016 rd_count  output  16  saturating count of accepted reads.
REQ-017 wr_count  output  16  saturating count of accepted writes.

Function
REQ-018 The block SHALL implement the responder end of the HIR memref read/write port protocol: the initiator drives addr/en; the responder returns data with no back-pressure.
REQ-019 Two-state FSM: CLEAR and SERVE; reset enters CLEAR with clear pointer 0.
REQ-020 In CLEAR, one word per cycle SHALL be written to zero at the clear pointer, pointer +1; after writing DEPTH-1, next state SERVE. CLEAR therefore lasts exactly DEPTH cycles.
REQ-021 busy SHALL be 1 exactly while state is CLEAR.
REQ-022 In CLEAR, rd_en and wr_en SHALL be ignored (no storage change, no rd_valid, counters unchanged) and SHALL set access_err.
REQ-023 In SERVE, a write with wr_en=1 SHALL update storage[wr_addr] at that clock edge.
REQ-024 In SERVE, a read with rd_en=1 at edge N SHALL produce rd_valid=1 and rd_data=storage[rd_addr] (value before any same-edge write) in the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles later.
REQ-025 Read and write to the same address on the same edge SHALL return the old word (read-first).
REQ-026 Back-to-back reads SHALL be accepted every cycle; responses emerge in order through a RD_LATENCY-deep valid/data pipeline.
REQ-027 When no response is due, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-028 rd_count/wr_count SHALL increment by 1 per accepted read/write and saturate at 16'hFFFF.
REQ-029 access_err SHALL clear only on reset.
REQ-030 Simultaneous rd_en and wr_en to different addresses SHALL both be served in the same cycle.

Reset
REQ-031 On rst_n=0 at a rising edge: state CLEAR, clear pointer 0, rd_valid 0, rd_data 0, read pipeline flushed, access_err 0, rd_count 0, wr_count 0; busy reads 1 from the following cycle.
REQ-032 Storage contents SHALL NOT be reset directly; they are zeroed only by the CLEAR sequence.
REQ-033 Reset asserted mid-CLEAR or mid-SERVE SHALL restart CLEAR from pointer 0 and drop in-flight read responses.

Verification
REQ-034 Reset, then idle: busy=1 for exactly 64 cycles, then 0; reads of addresses 0, 31, 63 return 0 with rd_valid after 1 cycle.
REQ-035 Write 32'hDEADBEEF to addr 5, read addr 5 next cycle -> rd_data=32'hDEADBEEF, rd_valid=1 one cycle later; wr_count=1, rd_count=1.
REQ-036 Same edge: write 32'h1 to addr 9 (prior value 32'h7), read addr 9 -> returns 32'h7; a read on the next edge returns 32'h1.
REQ-037 RD_LATENCY=3, reads at addrs 1,2,3 on consecutive cycles -> three consecutive rd_valid pulses beginning 3 cycles after the first read, data in order.
REQ-038 rd_en=1 during cycle 10 of CLEAR -> no rd_valid, rd_count stays 0, access_err=1 until next reset.
REQ-039 Reset pulse one cycle after a read -> no rd_valid for that read; busy=1 again for 64 cycles; previously written words read back 0.
